// File: rtl/pump_star_delta_starter.sv
// rtl/pump_star_delta_starter.sv - star-delta motor starter: lockout, transfer dead time, contactor feedback supervision
// Optional feature macro: STARTER_RUNHOUR_EN (accumulated DELTA run-seconds counter).
module pump_star_delta_starter #(
  parameter int CLK_HZ        = 25_000_000,
  parameter int STAR_MS       = 3000,
  parameter int TRANSFER_MS   = 50,
  parameter int MIN_OFF_MS    = 5000,
  parameter int FB_TIMEOUT_MS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pump_req,
  input  logic        fault_in,
  input  logic        run_fb_raw,
  output logic        k_main,
  output logic        k_star,
  output logic        k_delta,
  output logic        running,
  output logic        start_fail,
  output logic [31:0] run_seconds
);

  localparam int TICK_CYC = CLK_HZ / 1000;
  localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_CYC - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_STAR,
    S_TRANSFER,
    S_DELTA,
    S_LOCKOUT,
    S_FAIL
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          fb_meta;
  logic          run_fb;
  logic [PW-1:0] prescale;
  logic          ms_tick;
  logic [31:0]   timer_ms;
  logic [31:0]   loss_ms;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_meta <= 1'b0;
      run_fb  <= 1'b0;
    end else begin
      fb_meta <= run_fb_raw;
      run_fb  <= fb_meta;
    end
  end

  assign ms_tick = (prescale == PRE_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= '0;
    end else if (ms_tick) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + PW'(1);
    end
  end

  // True on the edge that completes the limit-th ms: counts the tick landing on this edge.
  function automatic logic reached(input logic [31:0] count, input logic tick, input int limit);
    reached = (count >= 32'(limit)) || (tick && (count >= 32'(limit - 1)));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_ms <= '0;
    end else if (state_next != state) begin
      timer_ms <= '0;
    end else if (ms_tick && (timer_ms != '1)) begin
      timer_ms <= timer_ms + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_ms <= '0;
    end else if ((state != S_DELTA) || run_fb) begin
      loss_ms <= '0;
    end else if (ms_tick && (loss_ms != '1)) begin
      loss_ms <= loss_ms + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_OFF;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if ((state != S_FAIL) && fault_in) begin
      state_next = S_FAIL;
    end else begin
      case (state)
        S_OFF: begin
          if (pump_req) state_next = S_STAR;
        end
        S_STAR: begin
          if (!pump_req) begin
            state_next = S_LOCKOUT;
          end else if (!run_fb && reached(timer_ms, ms_tick, FB_TIMEOUT_MS)) begin
            state_next = S_FAIL;
          end else if (run_fb && reached(timer_ms, ms_tick, STAR_MS)) begin
            state_next = S_TRANSFER;
          end
        end
        S_TRANSFER: begin
          if (!pump_req) begin
            state_next = S_LOCKOUT;
          end else if (reached(timer_ms, ms_tick, TRANSFER_MS)) begin
            state_next = S_DELTA;
          end
        end
        S_DELTA: begin
          if (!pump_req) begin
            state_next = S_LOCKOUT;
          end else if (!run_fb && reached(loss_ms, ms_tick, FB_TIMEOUT_MS)) begin
            state_next = S_FAIL;
          end
        end
        S_LOCKOUT: begin
          if (reached(timer_ms, ms_tick, MIN_OFF_MS)) state_next = S_OFF;
        end
        default: state_next = S_FAIL;
      endcase
    end
  end

  // Moore decode: an async rst forces S_OFF, so every coil drops without waiting for a clock.
  always_comb begin
    k_main     = 1'b0;
    k_star     = 1'b0;
    k_delta    = 1'b0;
    running    = 1'b0;
    start_fail = 1'b0;
    case (state)
      S_STAR: begin
        k_main = 1'b1;
        k_star = 1'b1;
      end
      S_TRANSFER: k_main = 1'b1;
      S_DELTA: begin
        k_main  = 1'b1;
        k_delta = 1'b1;
        running = 1'b1;
      end
      S_FAIL:  start_fail = 1'b1;
      default: ;
    endcase
  end

`ifdef STARTER_RUNHOUR_EN
  logic [9:0]  sub_ms;
  logic [31:0] seconds;

  // Sub-second residue survives stops so short runs still add up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_ms  <= '0;
      seconds <= '0;
    end else if ((state == S_DELTA) && ms_tick) begin
      if (sub_ms == 10'd999) begin
        sub_ms <= '0;
        if (seconds != '1) seconds <= seconds + 32'd1;
      end else begin
        sub_ms <= sub_ms + 10'd1;
      end
    end
  end

  assign run_seconds = seconds;
`else
  assign run_seconds = 32'd0;
`endif

endmodule
